input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive stable synchronised samples required to accept a level change (legal range 2..255).
REQ-002 SHALL have parameter STUCK, default 255: cycles a pedestrian button may stay accepted-high before it is declared stuck (must exceed DEBOUNCE).
REQ-003 SHALL have parameter EMER_HOLD, default 8: minimum cycles an accepted emergency output stays high (>= 1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all flops on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports T1pedButton_raw and T2pedButton_raw, input, 1 bit each: asynchronous pedestrian buttons.
REQ-007 SHALL have ports Emergency_Left_raw and Emergency_Right_raw, input, 1 bit each: asynchronous emergency requests.
REQ-008 SHALL have ports T1pedButton and T2pedButton, output, 1 bit each: clean, glitch-free button levels for the traffic controller.
REQ-009 SHALL have ports Emergency_Left and Emergency_Right, output, 1 bit each: clean emergency levels.
REQ-010 SHALL have port stuckFault, output, 2 bits: bit0 = T1 button stuck, bit1 = T2 button stuck.

Function
REQ-011 SHALL pass every raw input through a 2-flop synchroniser before any other logic.
REQ-012 SHALL run one independent channel FSM per input, with states IDLE, ARM, PRESSED, REL, plus FAULT on pedestrian channels only.
REQ-013 IDLE: output 0; a synchronised 1 moves the channel to ARM and loads the counter to 1.
REQ-014 ARM: each synchronised 1 increments the counter; reaching DEBOUNCE moves the channel to PRESSED with output 1; any 0 returns it to IDLE, counter cleared.
REQ-015 Rise latency SHALL be exactly 2+DEBOUNCE rising edges from the first edge sampling a stable raw 1 to output high.
REQ-016 PRESSED: output 1; a synchronised 0 moves the channel to REL with counter 1.
REQ-017 REL: output held 1; DEBOUNCE consecutive 0s move the channel to IDLE with output 0; any 1 returns it to PRESSED.
REQ-018 Pedestrian PRESSED/REL SHALL count total high-acceptance cycles; reaching STUCK moves the channel to FAULT, output 0, and sets the stuckFault bit.
REQ-019 FAULT: output 0; DEBOUNCE consecutive 0s clear the stuckFault bit and move the channel to IDLE; 1s restart that count.
REQ-020 Emergency channels SHALL hold output 1 for at least EMER_HOLD cycles after entering PRESSED; REL counting starts only after the hold expires.
REQ-021 Simultaneous left and right emergencies SHALL both pass through unarbitrated; channels never interact.
REQ-022 Counters SHALL saturate, never wrap; widths SHALL be sized by clog2 of the relevant parameter plus 1.
REQ-023 Glitches shorter than DEBOUNCE synchronised cycles SHALL never change any output.

Reset
REQ-024 While reset_n is 0, all channels SHALL be IDLE, counters 0, synchroniser flops 0, and all outputs including stuckFault 0.
REQ-025 Reset asserted mid-operation (any state) SHALL force REQ-024 immediately; after release a held-high input is re-qualified from IDLE.

Structure
REQ-026 State encodings and default parameter values SHALL live in shared package traffic_pkg, alongside the controller's light-state constants.
REQ-027 One sub-module, debounce_channel (parameters DEBOUNCE, STUCK, HOLD, STUCK_EN), SHALL be instantiated four times; the top is wiring only.

Verification (DEBOUNCE=4, STUCK=16, EMER_HOLD=8)
REQ-028 T1 raw high held 20 cycles -> T1pedButton rises on edge 6 after first sampled 1, falls 6 edges after raw falls.
REQ-029 T2 raw pulse 1,1,1,0 repeated -> T2pedButton stays 0 throughout.
REQ-030 T1 raw held high 40 cycles -> output high 16 cycles then 0, stuckFault=01; raw low 6 cycles -> stuckFault=00.
REQ-031 Emergency_Left raw high 5 sync cycles then low -> Emergency_Left high >= 8 cycles, then falls 4 cycles later.
REQ-032 Both emergencies high, reset_n pulsed low mid-PRESSED -> all outputs 0 asynchronously; after release both re-rise 6 edges later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-controller types: input-channel FSM states, light states and
// default conditioning parameters.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT  = 4;
  localparam int unsigned STUCK_DEFAULT     = 255;
  localparam int unsigned EMER_HOLD_DEFAULT = 8;

  typedef enum logic [2:0] {
    CH_IDLE    = 3'd0,
    CH_ARM     = 3'd1,
    CH_PRESSED = 3'd2,
    CH_REL     = 3'd3,
    CH_FAULT   = 3'd4
  } ch_state_e;

  typedef enum logic [1:0] {
    LIGHT_GREEN   = 2'd0,
    LIGHT_YELLOW  = 2'd1,
    LIGHT_RED     = 2'd2,
    LIGHT_ALL_RED = 2'd3
  } light_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchroniser, debounce FSM, optional stuck
// detection (pedestrian) or minimum high hold (emergency).
module debounce_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int unsigned STUCK    = STUCK_DEFAULT,
  parameter int unsigned HOLD     = EMER_HOLD_DEFAULT,
  parameter bit          STUCK_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic stuck
);

  // The high-time counter measures stuck time or emergency hold, never both.
  localparam int unsigned HLIM = STUCK_EN ? STUCK : HOLD;
  localparam int unsigned CW   = $clog2(DEBOUNCE) + 1;
  localparam int unsigned HW   = $clog2(HLIM) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
  localparam logic [HW-1:0] HCNT_MAX = HW'(HLIM);

  logic [1:0]    sync_q;
  logic          smp;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic          level_d, stuck_d;
  logic          deb_done, hcnt_done;

  assign smp       = sync_q[1];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign hcnt_inc  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HW'(1);
  assign deb_done  = (cnt_inc == CNT_MAX);
  assign hcnt_done = (hcnt_inc == HCNT_MAX);

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    stuck_d = stuck;
    case (state_q)
      CH_IDLE: begin
        cnt_d = '0;
        if (smp) begin
          state_d = CH_ARM;
          cnt_d   = CW'(1);
        end
      end
      CH_ARM: begin
        if (!smp) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else if (deb_done) begin
          state_d = CH_PRESSED;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CH_PRESSED: begin
        hcnt_d = hcnt_inc;
        if (STUCK_EN && hcnt_done) begin
          state_d = CH_FAULT;
          cnt_d   = '0;
          stuck_d = 1'b1;
        end else if (!smp && (STUCK_EN || hcnt_done)) begin
          state_d = CH_REL;
          cnt_d   = CW'(1);
        end
      end
      CH_REL: begin
        hcnt_d = hcnt_inc;
        if (STUCK_EN && hcnt_done) begin
          state_d = CH_FAULT;
          cnt_d   = '0;
          stuck_d = 1'b1;
        end else if (smp) begin
          state_d = CH_PRESSED;
          cnt_d   = '0;
        end else if (deb_done) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CH_FAULT: begin
        if (smp) begin
          cnt_d = '0;
        end else if (deb_done) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
          stuck_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
        stuck_d = 1'b0;
      end
    endcase
    level_d = (state_d == CH_PRESSED) || (state_d == CH_REL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      level   <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      level   <= level_d;
      stuck   <= stuck_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the two pedestrian buttons and two emergency requests for the
// traffic controller; four independent channels, no arbitration.
module input_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEFAULT,
  parameter int unsigned STUCK     = STUCK_DEFAULT,
  parameter int unsigned EMER_HOLD = EMER_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       T1pedButton_raw,
  input  logic       T2pedButton_raw,
  input  logic       Emergency_Left_raw,
  input  logic       Emergency_Right_raw,
  output logic       T1pedButton,
  output logic       T2pedButton,
  output logic       Emergency_Left,
  output logic       Emergency_Right,
  output logic [1:0] stuckFault
);

  logic [1:0] emer_stuck_unused;

  debounce_channel #(
    .DEBOUNCE(DEBOUNCE), .STUCK(STUCK), .HOLD(EMER_HOLD), .STUCK_EN(1'b1)
  ) u_t1 (
    .clk(clk), .reset_n(reset_n), .raw(T1pedButton_raw),
    .level(T1pedButton), .stuck(stuckFault[0])
  );

  debounce_channel #(
    .DEBOUNCE(DEBOUNCE), .STUCK(STUCK), .HOLD(EMER_HOLD), .STUCK_EN(1'b1)
  ) u_t2 (
    .clk(clk), .reset_n(reset_n), .raw(T2pedButton_raw),
    .level(T2pedButton), .stuck(stuckFault[1])
  );

  debounce_channel #(
    .DEBOUNCE(DEBOUNCE), .STUCK(STUCK), .HOLD(EMER_HOLD), .STUCK_EN(1'b0)
  ) u_emer_left (
    .clk(clk), .reset_n(reset_n), .raw(Emergency_Left_raw),
    .level(Emergency_Left), .stuck(emer_stuck_unused[0])
  );

  debounce_channel #(
    .DEBOUNCE(DEBOUNCE), .STUCK(STUCK), .HOLD(EMER_HOLD), .STUCK_EN(1'b0)
  ) u_emer_right (
    .clk(clk), .reset_n(reset_n), .raw(Emergency_Right_raw),
    .level(Emergency_Right), .stuck(emer_stuck_unused[1])
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output-vector changes with their
// cycle numbers; the monitor pops one entry per observed change.
module tb_input_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned STK = 16;
  localparam int unsigned HLD = 8;
  localparam int unsigned LAT = 2 + DEB;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       t1_raw = 1'b0, t2_raw = 1'b0, el_raw = 1'b0, er_raw = 1'b0;
  logic       t1, t2, el, er;
  logic [1:0] stuck_fault;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  logic [5:0] cur_vec, prev_vec = 6'b0;
  ev_t        ev;

  input_conditioner #(.DEBOUNCE(DEB), .STUCK(STK), .EMER_HOLD(HLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .T1pedButton_raw(t1_raw), .T2pedButton_raw(t2_raw),
    .Emergency_Left_raw(el_raw), .Emergency_Right_raw(er_raw),
    .T1pedButton(t1), .T2pedButton(t2),
    .Emergency_Left(el), .Emergency_Right(er),
    .stuckFault(stuck_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [5:0] out_vec();
    return {stuck_fault, er, el, t2, t1};
  endfunction

  task automatic push(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  // Monitor: every change of the output vector must match the next queued event
  always @(posedge clk) begin
    #1;
    cur_vec = out_vec();
    if (cur_vec !== prev_vec) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%b expected no change from %b",
                 cyc, cur_vec, prev_vec);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc != cyc) begin
          failures++;
          $display("FAIL event_cycle got=%0d expected=%0d vec=%b", cyc, ev.cyc, cur_vec);
        end
        checks++;
        if (cur_vec !== ev.vec) begin
          failures++;
          $display("FAIL event_value cyc=%0d got=%b expected=%b", cyc, cur_vec, ev.vec);
        end
      end
    end
    prev_vec = cur_vec;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step(3);
    chk("reset_outputs", out_vec(), 6'b0);
    reset_n = 1'b1;
    step(3);

    // Clean press and release on T1
    n = cyc;
    t1_raw = 1'b1;
    push(n + LAT, 6'b000001);
    step(10);
    t1_raw = 1'b0;
    push(cyc + LAT, 6'b000000);
    step(12);

    // Pulse exactly DEBOUNCE long is accepted
    n = cyc;
    t1_raw = 1'b1;
    push(n + LAT, 6'b000001);
    step(DEB);
    t1_raw = 1'b0;
    push(cyc + LAT, 6'b000000);
    step(12);

    // Short release bounce while pressed keeps the output high
    n = cyc;
    t1_raw = 1'b1;
    push(n + LAT, 6'b000001);
    step(8);
    t1_raw = 1'b0;
    step(2);
    t1_raw = 1'b1;
    step(2);
    t1_raw = 1'b0;
    push(cyc + LAT, 6'b000000);
    step(12);

    // Glitches shorter than DEBOUNCE never reach any output
    repeat (4) begin
      t2_raw = 1'b1;
      step(3);
      t2_raw = 1'b0;
      step(1);
    end
    el_raw = 1'b1;
    step(1);
    el_raw = 1'b0;
    step(2);
    er_raw = 1'b1;
    step(DEB - 1);
    er_raw = 1'b0;
    step(10);
    chk("glitch_quiet", out_vec(), 6'b0);

    // Stuck T1: high for STUCK cycles, then fault until DEBOUNCE lows
    n = cyc;
    t1_raw = 1'b1;
    push(n + LAT, 6'b000001);
    push(n + LAT + STK, 6'b010000);
    step(40);
    chk("stuck_flag_set", out_vec(), 6'b010000);
    t1_raw = 1'b0;
    push(cyc + LAT, 6'b000000);
    step(12);

    // Emergency left minimum hold, then DEBOUNCE release
    n = cyc;
    el_raw = 1'b1;
    push(n + LAT, 6'b000100);
    step(5);
    el_raw = 1'b0;
    push(n + LAT + HLD + DEB - 1, 6'b000000);
    step(20);

    // Both emergencies, reset mid-PRESSED, re-qualify after release
    n = cyc;
    el_raw = 1'b1;
    er_raw = 1'b1;
    push(n + LAT, 6'b001100);
    step(8);
    #2;
    push(cyc + 1, 6'b000000);
    reset_n = 1'b0;
    #1;
    chk("async_reset", out_vec(), 6'b0);
    step(3);
    reset_n = 1'b1;
    push(cyc + LAT, 6'b001100);
    step(20);
    el_raw = 1'b0;
    er_raw = 1'b0;
    push(cyc + LAT, 6'b000000);
    step(12);

    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d expected=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
